// File: rtl/ln_stat_accum.sv
// ln_stat_accum: per-vector sum / mean / variance for the LayerNorm datapath.
// Consumes N signed elements over a valid/ready stream, accumulates sum and
// sum of squares, then presents sum, mean (floor) and E[x^2]-mean^2 on a
// held valid/ready result port. One vector in flight at a time.
// Optional feature macro: LN_STAT_VAR_CLAMP_EN clamps a negative variance
// (a floor-truncation artefact) to zero; without it the raw difference wraps.
module ln_stat_accum #(
  parameter int N          = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH+ADDR_WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0]            mean_out,
  output logic [2*WIDTH-1:0]          var_out,
  output logic                        busy
);

  localparam int SW = WIDTH + ADDR_WIDTH;      // sum accumulator
  localparam int PW = 2 * WIDTH;               // square / E[x^2] / variance
  localparam int QW = 2 * WIDTH + ADDR_WIDTH;  // sum-of-squares accumulator

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CALC  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [QW-1:0]         sumsq_q, sumsq_d;

  // Stage-1 snapshot taken in CALC; the variance subtract happens one cycle
  // later so the result lands two edges after the last element.
  logic                  s1_vld_q, s1_vld_d;
  logic [SW-1:0]         s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0]      s1_mean_q, s1_mean_d;
  logic [PW-1:0]         s1_ex2_q, s1_ex2_d;

  logic                  out_valid_q, out_valid_d;
  logic [SW-1:0]         sum_out_q, sum_out_d;
  logic [WIDTH-1:0]      mean_out_q, mean_out_d;
  logic [PW-1:0]         var_out_q, var_out_d;

  logic                  accept;
  logic [SW-1:0]         x_ext;
  logic [PW-1:0]         x_pw;
  logic [PW-1:0]         x_sq;
  logic [QW-1:0]         x_sq_ext;
  logic [PW-1:0]         mean_pw;
  logic [PW-1:0]         mean_sq;
  logic [PW-1:0]         var_c;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);

  // Element sign-extended to the sum width; square is always nonnegative
  // and fits PW bits even for the most negative input.
  assign x_ext    = {{ADDR_WIDTH{in_data[WIDTH-1]}}, in_data};
  assign x_pw     = {{WIDTH{in_data[WIDTH-1]}}, in_data};
  assign x_sq     = x_pw * x_pw;
  assign x_sq_ext = {{ADDR_WIDTH{1'b0}}, x_sq};

  // mean^2 from the registered mean; product fits PW bits and is nonnegative.
  assign mean_pw  = {{WIDTH{s1_mean_q[WIDTH-1]}}, s1_mean_q};
  assign mean_sq  = mean_pw * mean_pw;

`ifdef LN_STAT_VAR_CLAMP_EN
  localparam int DW = 2 * WIDTH + 1;
  logic signed [DW-1:0] diff;
  // Floor of mean can make E[x^2]-mean^2 slightly negative; report zero.
  assign diff  = $signed({1'b0, s1_ex2_q}) - $signed({1'b0, mean_sq});
  assign var_c = diff[DW-1] ? '0 : diff[PW-1:0];
`else
  // Raw difference; a negative result wraps modulo 2^PW.
  assign var_c = s1_ex2_q - mean_sq;
`endif

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    s1_vld_d    = s1_vld_q;
    s1_sum_d    = s1_sum_q;
    s1_mean_d   = s1_mean_q;
    s1_ex2_d    = s1_ex2_q;
    out_valid_d = out_valid_q;
    sum_out_d   = sum_out_q;
    mean_out_d  = mean_out_q;
    var_out_d   = var_out_q;

    if (flush) begin
      state_d     = S_IDLE;
      count_d     = '0;
      sum_d       = '0;
      sumsq_d     = '0;
      s1_vld_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // First element loads the accumulators rather than adding to
          // whatever the previous vector left behind.
          if (accept) begin
            sum_d   = x_ext;
            sumsq_d = x_sq_ext;
            count_d = ADDR_WIDTH'(1);
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            sum_d   = sum_q + x_ext;
            sumsq_d = sumsq_q + x_sq_ext;
            if (count_q == ADDR_WIDTH'(N - 1)) begin
              count_d = '0;
              state_d = S_CALC;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        S_CALC: begin
          // Division by N is a right shift: the top WIDTH bits of the sum
          // are the arithmetic (floor) mean, likewise for E[x^2].
          s1_sum_d  = sum_q;
          s1_mean_d = sum_q[SW-1:ADDR_WIDTH];
          s1_ex2_d  = sumsq_q[QW-1:ADDR_WIDTH];
          s1_vld_d  = 1'b1;
          state_d   = S_HOLD;
        end
        S_HOLD: begin
          if (s1_vld_q) begin
            sum_out_d   = s1_sum_q;
            mean_out_d  = s1_mean_q;
            var_out_d   = var_c;
            out_valid_d = 1'b1;
            s1_vld_d    = 1'b0;
          end
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counter and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
    end
  end

  // Stage-1 snapshot of sum, mean and E[x^2].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sum_q  <= '0;
      s1_mean_q <= '0;
      s1_ex2_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sum_q  <= s1_sum_d;
      s1_mean_q <= s1_mean_d;
      s1_ex2_q  <= s1_ex2_d;
    end
  end

  // Result registers; held unchanged while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_out_q   <= '0;
      mean_out_q  <= '0;
      var_out_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_out_q   <= sum_out_d;
      mean_out_q  <= mean_out_d;
      var_out_q   <= var_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_out_q;
  assign mean_out  = mean_out_q;
  assign var_out   = var_out_q;

endmodule

// File: tb/tb_ln_stat_accum.sv
// Bench for ln_stat_accum (N=4, WIDTH=16): directed scenarios plus random
// vectors, checked against an integer-arithmetic reference model.
module tb_ln_stat_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] sum_out;
  logic [15:0] mean_out;
  logic [31:0] var_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef int vec_t [4];

  ln_stat_accum #(.N(4), .WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .mean_out  (mean_out),
    .var_out   (var_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer statistics of the vector.
  function automatic void model(input vec_t e, output logic [17:0] s,
                                output logic [15:0] m, output logic [31:0] v);
    longint sum, sq, mq, ex2, diff;
    sum = 0;
    sq  = 0;
    foreach (e[i]) begin
      sum += e[i];
      sq  += longint'(e[i]) * longint'(e[i]);
    end
    mq = sum / 4;
    if ((sum % 4) != 0 && sum < 0) mq = mq - 1;  // floor division
    ex2  = sq / 4;
    diff = ex2 - mq * mq;
`ifdef LN_STAT_VAR_CLAMP_EN
    if (diff < 0) diff = 0;
`endif
    s = 18'(sum);
    m = 16'(mq);
    v = 32'(diff);
  endfunction

  // Offer n elements; gap idle cycles before each after the first (-1 random).
  // Returns at the negedge following the last accept edge.
  task automatic send_vec(input vec_t e, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 16'(e[i]);
      chk("in_ready_offer", in_ready, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Result timing, values, stability while stalled, and the handshake.
  task automatic check_result(input vec_t e, input int hold, input string tag);
    logic [17:0] es;
    logic [15:0] em;
    logic [31:0] ev;
    model(e, es, em, ev);
    in_valid  = 1'b1;             // must be ignored until back in IDLE
    in_data   = 16'hBEEF;
    out_ready = (hold == 0);
    chk({tag, "_calc_valid"}, out_valid, 1'b0);
    chk({tag, "_calc_ready"}, in_ready, 1'b0);
    chk({tag, "_calc_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_lat1_valid"}, out_valid, 1'b0);
    chk({tag, "_lat1_ready"}, in_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum_out, es);
    chk({tag, "_mean"}, mean_out, em);
    chk({tag, "_var"}, var_out, ev);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_held_valid"}, out_valid, 1'b1);
      chk({tag, "_held_sum"}, sum_out, es);
      chk({tag, "_held_var"}, var_out, ev);
      chk({tag, "_held_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 1'b0);
    chk({tag, "_done_busy"}, busy, 1'b0);
    chk({tag, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    vec_t v;
    logic signed [15:0] r;

    // Reset state
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum_out, 18'd0);
    chk("rst_mean", mean_out, 16'd0);
    chk("rst_var", var_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic vector, immediate acceptance
    v = '{1, 2, 3, 4};
    send_vec(v, 4, 0);
    check_result(v, 0, "t1");
    chk("t1_sum_const", sum_out, 18'd10);
    chk("t1_var_const", var_out, 32'd3);

    // 2: all negative
    v = '{-4, -4, -4, -4};
    send_vec(v, 4, 0);
    check_result(v, 0, "t2");
    chk("t2_sum_const", sum_out, 18'h3FFF0);
    chk("t2_mean_const", mean_out, 16'hFFFC);

    // 3: floor-truncation artefact in the variance
    v = '{-1, 0, 0, 0};
    send_vec(v, 4, 0);
    check_result(v, 0, "t3");
`ifdef LN_STAT_VAR_CLAMP_EN
    chk("t3_var_const", var_out, 32'h0);
`else
    chk("t3_var_const", var_out, 32'hFFFF_FFFF);
`endif

    // 4: gapped input, stalled consumer
    v = '{10, 20, 30, 40};
    send_vec(v, 4, 1);
    check_result(v, 5, "t4");
    chk("t4_var_const", var_out, 32'd125);

    // 5a: flush mid-vector, offered element dropped
    v = '{7, 9, 11, 13};
    send_vec(v, 2, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd99;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_busy", busy, 1'b0);
    chk("t5_flush_ready", in_ready, 1'b1);
    v = '{1, 2, 3, 4};
    send_vec(v, 4, 0);
    check_result(v, 0, "t5");

    // 5b: flush during HOLD beats out_ready
    send_vec(v, 4, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5h_valid", out_valid, 1'b1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("t5h_drop_valid", out_valid, 1'b0);
    chk("t5h_drop_busy", busy, 1'b0);
    chk("t5h_drop_ready", in_ready, 1'b1);

    // Random vectors, random gaps and consumer stalls
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i] = -32768;
          1:       v[i] = 32767;
          default: begin
            r    = 16'($urandom);
            v[i] = r;
          end
        endcase
      end
      send_vec(v, 4, -1);
      check_result(v, int'($urandom_range(0, 3)), "rnd");
    end

    // 6: asynchronous reset mid-accumulation
    v = '{100, 200, 300, 400};
    send_vec(v, 4, 0);
    check_result(v, 0, "t6pre");
    send_vec(v, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_sum", sum_out, 18'd0);
    chk("t6_rst_var", var_out, 32'd0);
    chk("t6_rst_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{5, 5, 5, 5};
    send_vec(v, 4, 0);
    check_result(v, 0, "t6");
    chk("t6_sum_const", sum_out, 18'd20);
    chk("t6_mean_const", mean_out, 16'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
